// File: rtl/id_fwd_scoreboard.sv
// ID-stage forwarding scoreboard: tracks in-flight writes per downstream slot and
// resolves each source operand to a forwarded value, the register-file value or a stall.
// Optional statistics counters are enabled with `define SCOREBOARD_STATS_EN.
module id_fwd_scoreboard #(
  parameter int NUM_STG = 3,
  parameter int STG_W   = 2,
  parameter int REG_AW  = 5,
  parameter int DW      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  id_issue,
  input  logic [REG_AW-1:0]     id_wdest,
  input  logic [STG_W-1:0]      id_avail,
  input  logic [NUM_STG-1:0]    stage_adv,
  input  logic [NUM_STG*DW-1:0] stage_result,
  input  logic [REG_AW-1:0]     rs,
  input  logic [REG_AW-1:0]     rt,
  input  logic                  rs_used,
  input  logic                  rt_used,
  input  logic [DW-1:0]         rf_rs_value,
  input  logic [DW-1:0]         rf_rt_value,
  output logic [DW-1:0]         rs_value,
  output logic [DW-1:0]         rt_value,
  output logic                  rs_wait,
  output logic                  rt_wait,
  output logic                  issue_err
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]           stat_stall_cyc,
  output logic [31:0]           stat_fwd_rs,
  output logic [31:0]           stat_fwd_rt
`endif
);

  logic              valid_reg [NUM_STG];
  logic [REG_AW-1:0] wdest_reg [NUM_STG];
  logic [STG_W-1:0]  avail_reg [NUM_STG];
  logic              valid_next [NUM_STG];
  logic [REG_AW-1:0] wdest_next [NUM_STG];
  logic [STG_W-1:0]  avail_next [NUM_STG];
  logic              err_next;
  logic              issue_ok;

  always_comb begin
    for (int i = 0; i < NUM_STG; i++) begin
      valid_next[i] = valid_reg[i];
      wdest_next[i] = wdest_reg[i];
      avail_next[i] = avail_reg[i];
      if (stage_adv[i]) valid_next[i] = 1'b0;
    end
    // Slot i takes whatever slot i-1 held, bubbles included.
    for (int i = 1; i < NUM_STG; i++) begin
      if (stage_adv[i-1]) begin
        valid_next[i] = valid_reg[i-1];
        wdest_next[i] = wdest_reg[i-1];
        avail_next[i] = avail_reg[i-1];
      end
    end
    issue_ok = id_issue & (~valid_reg[0] | stage_adv[0]);
    if (issue_ok) begin
      valid_next[0] = 1'b1;
      wdest_next[0] = id_wdest;
      avail_next[0] = id_avail;
    end
    err_next = issue_err | (id_issue & valid_reg[0] & ~stage_adv[0]);
    if (flush) begin
      for (int i = 0; i < NUM_STG; i++) valid_next[i] = 1'b0;
      err_next = issue_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STG; i++) begin
        valid_reg[i] <= 1'b0;
        wdest_reg[i] <= '0;
        avail_reg[i] <= '0;
      end
      issue_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_STG; i++) begin
        valid_reg[i] <= valid_next[i];
        wdest_reg[i] <= wdest_next[i];
        avail_reg[i] <= avail_next[i];
      end
      issue_err <= err_next;
    end
  end

  logic [REG_AW-1:0] op_num  [2];
  logic              op_used [2];
  logic [DW-1:0]     op_rf   [2];
  logic [DW-1:0]     op_val  [2];
  logic              op_wait [2];
  logic              op_fwd  [2];

  assign op_num[0]  = rs;
  assign op_num[1]  = rt;
  assign op_used[0] = rs_used;
  assign op_used[1] = rt_used;
  assign op_rf[0]   = rf_rs_value;
  assign op_rf[1]   = rf_rt_value;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lookup
      logic          hit;
      logic          ready;
      logic [DW-1:0] sel_val;

      // Scan oldest to youngest so the lowest matching slot is the last to win.
      always_comb begin
        hit     = 1'b0;
        ready   = 1'b0;
        sel_val = '0;
        for (int i = NUM_STG - 1; i >= 0; i--) begin
          if (valid_reg[i] && (wdest_reg[i] == op_num[gi]) && (op_num[gi] != '0)) begin
            hit     = 1'b1;
            ready   = (i >= int'(avail_reg[i]));
            sel_val = stage_result[i*DW +: DW];
          end
        end
        op_fwd[gi]  = op_used[gi] & hit & ready;
        op_wait[gi] = op_used[gi] & hit & ~ready;
        op_val[gi]  = op_fwd[gi] ? sel_val : op_rf[gi];
      end
    end
  endgenerate

  assign rs_value = op_val[0];
  assign rt_value = op_val[1];
  assign rs_wait  = op_wait[0];
  assign rt_wait  = op_wait[1];

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_stall_cyc <= '0;
      stat_fwd_rs    <= '0;
      stat_fwd_rt    <= '0;
    end else begin
      if ((op_wait[0] | op_wait[1]) && (stat_stall_cyc != '1)) stat_stall_cyc <= stat_stall_cyc + 32'd1;
      if (op_fwd[0] && (stat_fwd_rs != '1)) stat_fwd_rs <= stat_fwd_rs + 32'd1;
      if (op_fwd[1] && (stat_fwd_rt != '1)) stat_fwd_rt <= stat_fwd_rt + 32'd1;
    end
  end
`endif

endmodule
